// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-state recovery and
// optional sequence-period measurement enabled by the LFSR_PERIOD_EN macro.
module lfsr_gen #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
  parameter logic [WIDTH-1:0] GTAPS      = 8'h1D,
  parameter logic [WIDTH-1:0] RESET_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic [WIDTH-1:0] data,
  output logic             out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & GTAPS);
  endfunction

  logic [WIDTH-1:0] state_r;
  logic             lockup_r;
  logic             zero_s;
  logic [WIDTH-1:0] next_s;

  // Next state for an enabled step; the all-zero state is forced out to 1.
  always_comb begin
    zero_s = (state_r == ZERO);
    next_s = state_r;
    if (zero_s) begin
      next_s = ONE;
    end else if (mode) begin
      next_s = gal_step(state_r);
    end else begin
      next_s = fib_step(state_r);
    end
  end

  // State register and lock-up pulse: load beats en beats hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= RESET_SEED;
      lockup_r <= 1'b0;
    end else if (load) begin
      state_r  <= seed;
      lockup_r <= 1'b0;
    end else if (en) begin
      state_r  <= next_s;
      lockup_r <= zero_s;
    end else begin
      lockup_r <= 1'b0;
    end
  end

  assign data   = state_r;
  assign out    = state_r[WIDTH-1];
  assign lockup = lockup_r;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] period_r;
  logic             wrap_r;
  logic [WIDTH-1:0] cnt_inc_s;
  logic             hit_s;

  // Saturating step count and detection of a return to the start value.
  always_comb begin
    cnt_inc_s = (cnt_r == ONES) ? cnt_r : (cnt_r + ONE);
    hit_s     = 1'b0;
    if (!zero_s && (start_r != ZERO) && (next_s == start_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Period measurement registers; a load restarts counting from the new seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r  <= RESET_SEED;
      cnt_r    <= ZERO;
      period_r <= ZERO;
      wrap_r   <= 1'b0;
    end else if (load) begin
      start_r <= seed;
      cnt_r   <= ZERO;
      wrap_r  <= 1'b0;
    end else if (en) begin
      if (hit_s) begin
        period_r <= cnt_inc_s;
        cnt_r    <= ZERO;
        wrap_r   <= 1'b1;
      end else begin
        cnt_r  <= cnt_inc_s;
        wrap_r <= 1'b0;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign wrap   = wrap_r;
  assign period = period_r;
`else
  assign wrap   = 1'b0;
  assign period = ZERO;
`endif

endmodule
